// File: rtl/dm_wait_responder_pkg.sv
// Shared types and constants for the data-memory wait-state responder.
package dm_wait_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    // Encodings 101..111 are reserved and reported as errors.
    function automatic logic dm_type_legal(input logic [2:0] t);
        return (t <= DM_BYTE_U);
    endfunction

endpackage

// File: rtl/dm_wait_responder_if.sv
// Request/response bundle between the CPU data port and the responder.
interface dm_wait_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_dmtype;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_dmtype,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_dmtype,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_wait_responder_lane_align.sv
// Byte-lane steering: store lane enables/replicated data and load extraction/extension.
module dm_wait_responder_lane_align
    import dm_wait_responder_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_dmtype,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata_ext,
    output logic        o_misalign
);

    logic [31:0] w_shifted;

    // Selected lane(s) moved down to bit 0 for loads.
    assign w_shifted = i_rword >> {i_addr, 3'b000};

    // Decode access size into lane enables, store data and extended load data.
    always_comb begin
        o_be        = 4'b0000;
        o_wword     = '0;
        o_rdata_ext = '0;
        o_misalign  = 1'b0;
        case (i_dmtype)
            DM_WORD: begin
                o_be        = 4'b1111;
                o_wword     = i_wdata;
                o_rdata_ext = i_rword;
                o_misalign  = (i_addr != 2'b00);
            end
            DM_HALF, DM_HALF_U: begin
                o_be        = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wword     = {2{i_wdata[15:0]}};
                o_rdata_ext = (i_dmtype == DM_HALF) ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                                    : {16'h0000, w_shifted[15:0]};
                o_misalign  = i_addr[0];
            end
            DM_BYTE, DM_BYTE_U: begin
                o_be        = 4'b0001 << i_addr;
                o_wword     = {4{i_wdata[7:0]}};
                o_rdata_ext = (i_dmtype == DM_BYTE) ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                                    : {24'h000000, w_shifted[7:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_wait_responder.sv
// Word-organised RAM responder with a fixed programmable wait-state latency.
module dm_wait_responder
    import dm_wait_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input logic               clk,
    input logic               rstn,
    dm_wait_responder_if.slave bus
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dm_wait_responder: LATENCY must be within 1..15");
    end

    logic          r_rstn_meta;
    logic          r_rstn_sync;
    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_ready;
    logic          r_resp_valid;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_dmtype;
    logic [31:0]   r_mem [0:DEPTH_WORDS-1];

    logic [IW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [3:0]    w_be;
    logic [31:0]   w_wword;
    logic [31:0]   w_rdata_ext;
    logic          w_misalign;
    logic          w_in_range;
    logic          w_err;
    logic          w_access;
    logic          w_commit;

    assign w_idx      = r_addr[IW+1:2];
    assign w_rword    = r_mem[w_idx];
    assign w_in_range = (r_addr[31:2] < 30'(DEPTH_WORDS));
    assign w_err      = w_misalign | ~dm_type_legal(r_dmtype) | ~w_in_range;
    assign w_access   = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_commit   = w_access && r_we && !w_err;

    dm_wait_responder_lane_align u_lane_align (
        .i_addr      (r_addr[1:0]),
        .i_dmtype    (r_dmtype),
        .i_wdata     (r_wdata),
        .i_rword     (w_rword),
        .o_be        (w_be),
        .o_wword     (w_wword),
        .o_rdata_ext (w_rdata_ext),
        .o_misalign  (w_misalign)
    );

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    // Reset asserts immediately but releases synchronously to clk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstn_meta <= 1'b0;
            r_rstn_sync <= 1'b0;
        end else begin
            r_rstn_meta <= 1'b1;
            r_rstn_sync <= r_rstn_meta;
        end
    end

    // Store commit; array contents survive reset, and a reset before the access edge drops the store.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

    // Access sequencer: accept in IDLE, count wait states, present a one-cycle response.
    always_ff @(posedge clk or negedge r_rstn_sync) begin
        if (!r_rstn_sync) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_dmtype     <= DM_WORD;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (bus.req_valid && r_ready) begin
                        r_we     <= bus.req_we;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_dmtype <= bus.req_dmtype;
                        r_cnt    <= CNT_LOAD;
                        r_ready  <= 1'b0;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_err        <= w_err;
                        r_rdata      <= (w_err || r_we) ? 32'h0 : w_rdata_ext;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_wait_responder.sv
// Scoreboard bench for dm_wait_responder: byte-array reference model, latency and handshake checks.
module tb_dm_wait_responder;
    import dm_wait_responder_pkg::*;

    localparam int DEPTH = 128;
    localparam int LAT   = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    dm_wait_responder_if bus();

    dm_wait_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        int          id;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         total    = 0;
    int         bad      = 0;
    int         cyc      = 0;
    int         resp_cnt = 0;
    int         resp_cyc[$];
    int         req_id   = 0;
    int         last_acc = 0;
    logic [7:0] model [0:DEPTH*4-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: byte-addressed memory, independent of the lane logic.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [2:0] t, output logic [31:0] rd, output logic e);
        int n;
        logic [31:0] v;
        n = (t == 3'd0) ? 4 : ((t == 3'd1 || t == 3'd2) ? 2 : 1);
        e = (t > 3'd4) || (n == 4 && addr[1:0] != 2'b00) || (n == 2 && addr[0])
            || (int'(addr[31:2]) >= DEPTH);
        rd = 32'h0;
        if (!e) begin
            if (we) begin
                for (int k = 0; k < n; k++) model[int'(addr) + k] = wd[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = model[int'(addr) + k];
                if (t == 3'd1) v = {{16{v[15]}}, v[15:0]};
                else if (t == 3'd3) v = {{24{v[7]}}, v[7:0]};
                rd = v;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: pop expectation, compare data, error and latency.
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            resp_cnt++;
            resp_cyc.push_back(cyc);
            check_eq("ready_low_in_resp", {31'b0, bus.req_ready}, 32'd0);
            check_eq("resp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check_eq($sformatf("r%0d_rdata", mon_e.id), bus.resp_rdata, mon_e.rdata);
                check_eq($sformatf("r%0d_err", mon_e.id), {31'b0, bus.resp_err}, {31'b0, mon_e.err});
                check_eq($sformatf("r%0d_latency", mon_e.id), 32'(cyc - mon_e.acc_cyc), 32'(LAT));
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] t, input bit hold, input bit expect_resp);
        exp_t e;
        int   w;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_dmtype = t;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            check_eq("ready_timeout", 32'(w), 32'd0);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (expect_resp) begin
            model_access(we, addr, wd, t, e.rdata, e.err);
            e.acc_cyc = cyc;
            e.id      = req_id;
            sb.push_back(e);
        end
        req_id++;
        @(negedge clk);
        if (hold) begin
            bus.req_we     = ~we;
            bus.req_addr   = addr ^ 32'h0000_0004;
            bus.req_wdata  = 32'hBAD0_BAD0;
            bus.req_dmtype = DM_BYTE;
        end else begin
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[3];
        int n0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_dmtype = DM_WORD;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        check_eq("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check_eq("rst_rdata", bus.resp_rdata, 32'd0);
        check_eq("rst_err", {31'b0, bus.resp_err}, 32'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("idle_no_resp", 32'(resp_cnt), 32'd0);

        // Word store then load
        send(1'b1, 32'h10, 32'hDEADBEEF, DM_WORD, 1'b0, 1'b1);
        send(1'b0, 32'h10, 32'h0, DM_WORD, 1'b0, 1'b1);
        drain();

        // Byte and halfword lanes
        send(1'b1, 32'h20, 32'h11223344, DM_WORD,   1'b0, 1'b1);
        send(1'b1, 32'h21, 32'h000000AA, DM_BYTE,   1'b0, 1'b1);
        send(1'b0, 32'h20, 32'h0,        DM_WORD,   1'b0, 1'b1);
        send(1'b0, 32'h21, 32'h0,        DM_BYTE,   1'b0, 1'b1);
        send(1'b0, 32'h21, 32'h0,        DM_BYTE_U, 1'b0, 1'b1);
        send(1'b1, 32'h22, 32'h00008001, DM_HALF,   1'b0, 1'b1);
        send(1'b0, 32'h20, 32'h0,        DM_WORD,   1'b0, 1'b1);
        send(1'b0, 32'h22, 32'h0,        DM_HALF,   1'b0, 1'b1);
        send(1'b0, 32'h22, 32'h0,        DM_HALF_U, 1'b0, 1'b1);
        send(1'b0, 32'h23, 32'h0,        DM_BYTE,   1'b0, 1'b1);
        drain();

        // Errors and range boundary
        send(1'b0, 32'h13,         32'h0,        DM_WORD, 1'b0, 1'b1);
        send(1'b1, 32'h21,         32'h0000FFFF, DM_HALF, 1'b0, 1'b1);
        send(1'b0, 32'h20,         32'h0,        DM_WORD, 1'b0, 1'b1);
        send(1'b0, 32'(DEPTH * 4), 32'h0,        DM_WORD, 1'b0, 1'b1);
        send(1'b1, 32'(DEPTH * 4), 32'h5A5A5A5A, DM_BYTE, 1'b0, 1'b1);
        send(1'b0, 32'h20,         32'h0,        3'b111,  1'b0, 1'b1);
        send(1'b1, 32'(DEPTH * 4 - 4), 32'hCAFEF00D, DM_WORD, 1'b0, 1'b1);
        send(1'b0, 32'(DEPTH * 4 - 4), 32'h0,        DM_WORD, 1'b0, 1'b1);
        drain();

        // Continuous valid, inputs disturbed during WAIT
        resp_cyc.delete();
        send(1'b1, 32'h40, 32'h12345678, DM_WORD, 1'b1, 1'b1);
        acc[0] = last_acc;
        send(1'b0, 32'h40, 32'h0,        DM_WORD, 1'b1, 1'b1);
        acc[1] = last_acc;
        send(1'b0, 32'h41, 32'h0,        DM_BYTE, 1'b1, 1'b1);
        acc[2] = last_acc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        drain();
        check_eq("hold_acc_gap0", 32'(acc[1] - acc[0]), 32'(LAT + 2));
        check_eq("hold_acc_gap1", 32'(acc[2] - acc[1]), 32'(LAT + 2));
        check_eq("hold_resp_count", 32'(resp_cyc.size()), 32'd3);
        if (resp_cyc.size() == 3) begin
            check_eq("hold_resp_gap0", 32'(resp_cyc[1] - resp_cyc[0]), 32'(LAT + 2));
            check_eq("hold_resp_gap1", 32'(resp_cyc[2] - resp_cyc[1]), 32'(LAT + 2));
        end
        send(1'b0, 32'h44, 32'h0, DM_WORD, 1'b0, 1'b1);
        drain();

        // Reset in the middle of a store
        send(1'b1, 32'h30, 32'h00000000, DM_WORD, 1'b0, 1'b1);
        drain();
        n0 = resp_cnt;
        send(1'b1, 32'h30, 32'h00000055, DM_WORD, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        check_eq("midrst_ready", {31'b0, bus.req_ready}, 32'd1);
        check_eq("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("midrst_no_resp", 32'(resp_cnt - n0), 32'd0);
        check_eq("midrst_idle_ready", {31'b0, bus.req_ready}, 32'd1);
        send(1'b0, 32'h30, 32'h0, DM_WORD, 1'b0, 1'b1);
        send(1'b0, 32'h10, 32'h0, DM_WORD, 1'b0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
